// File: rtl/strip_pkg.sv
// Shared types and default sizing for the strip allocator.
package strip_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } strip_state_t;

  localparam int STRIP_ID_W    = 4;
  localparam int STRIP_WIDTH_W = 8;
  localparam int STRIP_CAP_DEF = 128;
endpackage

// File: rtl/strip_fit_cmp.sv
// Per-strip fit test and best-candidate compare; one instance reused across scan cycles.
module strip_fit_cmp
  import strip_pkg::*;
#(
  parameter int WIDTH_W   = STRIP_WIDTH_W,
  parameter int STRIP_CAP = STRIP_CAP_DEF
) (
  input  logic [WIDTH_W-1:0] occ_i,
  input  logic [WIDTH_W-1:0] w_i,
  input  logic [WIDTH_W-1:0] best_i,
  input  logic               found_i,
  output logic               fits_o,
  output logic               take_o
);
  // One extra bit so occupancy + width never wraps past the capacity test.
  logic [WIDTH_W:0] sum;

  assign sum    = {1'b0, occ_i} + {1'b0, w_i};
  assign fits_o = (sum <= (WIDTH_W+1)'(STRIP_CAP));
  // Strict less-than keeps the lowest id on ties.
  assign take_o = fits_o && (!found_i || (occ_i < best_i));
endmodule

// File: rtl/strip_alloc_scan.sv
// Sequential least-occupied strip allocator: one strip examined per cycle, winner reserved on RESP entry.
module strip_alloc_scan
  import strip_pkg::*;
#(
  parameter int NUM_STRIPS = 12,
  parameter int ID_W       = STRIP_ID_W,
  parameter int WIDTH_W    = STRIP_WIDTH_W,
  parameter int STRIP_CAP  = STRIP_CAP_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [WIDTH_W-1:0] req_width_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [ID_W-1:0]    resp_id_o,
  output logic [WIDTH_W-1:0] resp_offset_o,
  output logic               resp_fail_o
);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_STRIPS - 1);

  strip_state_t       state_q, state_d;
  logic [WIDTH_W-1:0] occ_q [NUM_STRIPS];
  logic [WIDTH_W-1:0] w_q;
  logic [ID_W-1:0]    idx_q;
  logic               found_q, found_d;
  logic [ID_W-1:0]    best_id_q, best_id_d;
  logic [WIDTH_W-1:0] best_occ_q, best_occ_d;
  logic [ID_W-1:0]    resp_id_q;
  logic [WIDTH_W-1:0] resp_off_q;
  logic               resp_fail_q;

  logic               fits, take;
  logic [WIDTH_W-1:0] cand_occ;
  logic               accept, resp_done, scan_last;

  assign cand_occ  = occ_q[idx_q];
  assign accept    = (state_q == IDLE) && req_valid_i;
  assign resp_done = (state_q == RESP) && resp_ready_i;
  assign scan_last = (state_q == SCAN) && (idx_q == LAST_IDX);

  strip_fit_cmp #(
    .WIDTH_W   (WIDTH_W),
    .STRIP_CAP (STRIP_CAP)
  ) u_cmp (
    .occ_i   (cand_occ),
    .w_i     (w_q),
    .best_i  (best_occ_q),
    .found_i (found_q),
    .fits_o  (fits),
    .take_o  (take)
  );

  // Best-so-far including the strip examined this cycle.
  always_comb begin
    found_d    = found_q | take;
    best_id_d  = take ? idx_q : best_id_q;
    best_occ_d = take ? cand_occ : best_occ_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = SCAN;
      SCAN:    if (scan_last) state_d = RESP;
      RESP:    if (resp_done) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o   = (state_q == IDLE);
    resp_valid_o  = (state_q == RESP);
    resp_id_o     = resp_id_q;
    resp_offset_o = resp_off_q;
    resp_fail_o   = resp_fail_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      w_q         <= '0;
      idx_q       <= '0;
      found_q     <= 1'b0;
      best_id_q   <= '0;
      best_occ_q  <= '1;
      resp_id_q   <= '0;
      resp_off_q  <= '0;
      resp_fail_q <= 1'b0;
      for (int i = 0; i < NUM_STRIPS; i++) occ_q[i] <= '0;
    end else begin
      if (accept) begin
        w_q        <= req_width_i;
        idx_q      <= '0;
        found_q    <= 1'b0;
        best_id_q  <= '0;
        best_occ_q <= '1;
      end
      if (state_q == SCAN) begin
        idx_q      <= idx_q + 1'b1;
        found_q    <= found_d;
        best_id_q  <= best_id_d;
        best_occ_q <= best_occ_d;
      end
      // Reservation lands on the same edge that enters RESP.
      if (scan_last) begin
        resp_fail_q <= !found_d;
        resp_id_q   <= found_d ? best_id_d : '0;
        resp_off_q  <= found_d ? best_occ_d : '0;
        if (found_d) occ_q[best_id_d] <= best_occ_d + w_q;
      end
      if (resp_done) begin
        resp_id_q   <= '0;
        resp_off_q  <= '0;
        resp_fail_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_strip_alloc_scan.sv
// Directed bench for strip_alloc_scan with hand-computed expectations.
module tb_strip_alloc_scan;
  localparam int N = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_width = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [3:0] resp_id;
  logic [7:0] resp_off;
  logic       resp_fail;

  int n_chk  = 0;
  int n_fail = 0;

  strip_alloc_scan #(.NUM_STRIPS(N), .ID_W(4), .WIDTH_W(8), .STRIP_CAP(128)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clr),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_width_i   (req_width),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_id_o     (resp_id),
    .resp_offset_o (resp_off),
    .resp_fail_o   (resp_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_occ(input string tag, input int s, input int exp);
    chk(tag, 32'(dut.occ_q[s]), exp);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int s = 0; s < N; s++) chk_occ(tag, s, 0);
  endtask

  // Issue one request, wait for response, optionally stall, then accept it.
  task automatic req_expect(input string tag, input logic [7:0] w, input int hold,
                            input int exp_id, input int exp_off, input int exp_fail);
    int   lat;
    logic stable;
    logic [3:0] id;
    logic [7:0] off;
    logic fail;
    @(negedge clk);
    chk({tag, "_req_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_width = w;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, N + 1);
    id = resp_id; off = resp_off; fail = resp_fail;
    chk({tag, "_id"}, id, exp_id);
    chk({tag, "_offset"}, off, exp_off);
    chk({tag, "_fail"}, fail, exp_fail);
    if (hold > 0) begin
      stable = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (!resp_valid || resp_id !== id || resp_off !== off || resp_fail !== fail || req_ready)
          stable = 1'b0;
      end
      chk({tag, "_hold_stable"}, stable, 1);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_ready_after"}, req_ready, 1);
    chk({tag, "_valid_drop"}, resp_valid, 0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic seen;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_offset", resp_off, 0);
    chk("rst_fail", resp_fail, 0);
    rst = 1'b0;

    // Basic allocation, then a stalled response
    req_expect("s1a", 8'd10, 0, 0, 0, 0);
    req_expect("s1b", 8'd5, 5, 1, 0, 0);
    chk_occ("s1_occ0", 0, 10);
    chk_occ("s1_occ1", 1, 5);

    // Preload {40,20,20,50x8,60} then pick the first 20
    pulse_clear();
    chk_all_zero("s2_clear_occ");
    req_expect("s2_p0", 8'd40, 0, 0, 0, 0);
    req_expect("s2_p1", 8'd20, 0, 1, 0, 0);
    req_expect("s2_p2", 8'd20, 0, 2, 0, 0);
    for (int s = 3; s <= 10; s++) req_expect("s2_p50", 8'd50, 0, s, 0, 0);
    req_expect("s2_p11", 8'd60, 0, 11, 0, 0);
    req_expect("s2_pick", 8'd10, 0, 1, 20, 0);
    chk_occ("s2_occ1", 1, 30);
    chk_occ("s2_occ2", 2, 20);

    // Near-full strips, exact fill, oversize, width 0
    pulse_clear();
    for (int s = 0; s < N; s++) req_expect("s3_fill", 8'd125, 0, s, 0, 0);
    req_expect("s3_w4", 8'd4, 0, 0, 0, 1);
    chk_occ("s3_occ0_nochg", 0, 125);
    req_expect("s3_w3", 8'd3, 0, 0, 125, 0);
    chk_occ("s3_occ0_full", 0, 128);
    req_expect("s3_w200", 8'd200, 0, 0, 0, 1);
    req_expect("s3_w0", 8'd0, 0, 1, 125, 0);
    chk_occ("s3_occ1_w0", 1, 125);
    chk_occ("s3_occ0_w0", 0, 128);

    // Clear mid-SCAN
    @(negedge clk);
    req_valid = 1'b1;
    req_width = 8'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("s4_in_scan", req_ready, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("s4_ready_next", req_ready, 1);
    chk("s4_valid_low", resp_valid, 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("s4_no_resp", seen, 0);
    chk_all_zero("s4_occ");

    // Reset together with clear while a response is pending
    req_expect("s5a", 8'd9, 0, 0, 0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_width = 8'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (N) @(negedge clk);
    chk("s5_pending", resp_valid, 1);
    chk("s5_pending_id", resp_id, 1);
    rst = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    chk("s5_req_ready", req_ready, 1);
    chk("s5_resp_valid", resp_valid, 0);
    chk("s5_id", resp_id, 0);
    chk("s5_offset", resp_off, 0);
    chk("s5_fail", resp_fail, 0);
    chk_occ("s5_occ0", 0, 0);
    chk_occ("s5_occ1", 1, 0);
    rst = 1'b0;
    clr = 1'b0;
    req_expect("s5b", 8'd1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
